// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered bitwise logic unit with valid/ready handshake and accumulating XOR
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             last,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             zero,
  output logic             parity,
  output logic             acc_pend
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_ACC  = 3'b111
  } op_e;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result;
  logic             in_xfer;
  logic             out_xfer;
  logic             is_acc;
  logic             produce;

  // Handshake: the output register can take a new beat when empty or being drained now.
  always_comb begin
    in_ready = !rst && (!out_valid || out_ready);
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
    is_acc   = (op_e'(op) == OP_ACC);
    produce  = in_xfer && (!is_acc || last);
  end

  // Bitwise result for the current beat; the ACC case folds the running checksum in.
  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NAND: result = ~(A & B);
      OP_NOR:  result = ~(A | B);
      OP_XNOR: result = ~(A ^ B);
      OP_NOTA: result = ~A;
      OP_ACC:  result = acc ^ A ^ B;
      default: result = '0;
    endcase
  end

  // Output register: load on a producing beat, empty on a drain with nothing new, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Y         <= '0;
      zero      <= 1'b1;
      parity    <= 1'b0;
    end else if (produce) begin
      out_valid <= 1'b1;
      Y         <= result;
      zero      <= (result == '0);
      parity    <= ^result;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Running checksum: absorbs non-final ACC beats and clears once the final beat is emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      acc_pend <= 1'b0;
    end else if (in_xfer && is_acc) begin
      if (last) begin
        acc      <= '0;
        acc_pend <= 1'b0;
      end else begin
        acc      <= acc ^ A ^ B;
        acc_pend <= 1'b1;
      end
    end
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit for the ALU datapath; successor to the fixed 8-bit combinational gate blocks.
- Takes two WIDTH-bit operands and a 3-bit opcode through a valid/ready handshake and returns the result one cycle later in an output register with zero/parity flags.
- Adds a multi-beat accumulating-XOR mode (running checksum) that the combinational gates cannot provide.

Parameters:
- WIDTH, 8, operand/result width in bits (legal >= 1).

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous active-high reset
- in_valid  input  1  A/B/op/last valid this cycle
- in_ready  output  1  block can accept a beat this cycle
- op  input  3  operation select (see Behaviour)
- last  input  1  final beat of an accumulation; ignored unless op=111
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- out_valid  output  1  Y/zero/parity valid
- out_ready  input  1  consumer accepts result
- Y  output  WIDTH  registered result
- zero  output  1  registered: Y == 0
- parity  output  1  registered: XOR-reduce of Y
- acc_pend  output  1  accumulation in progress (>=1 non-last ACC beat absorbed)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates on rising clk only.
- Reset (rst=1 at edge): out_valid=0, Y=0, zero=1, parity=0, acc=0, acc_pend=0. in_ready=0 combinationally while rst=1. rst wins over any simultaneous transfer; an accumulation in progress is discarded.
- in_ready = !rst && (!out_valid || out_ready). Input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Opcodes (accepted beat, result registered next edge, latency 1): 000 A&B; 001 A|B; 010 A^B; 011 ~(A&B); 100 ~(A|B); 101 ~(A^B); 110 ~A (B ignored); 111 ACC_XOR.
- Non-ACC beat: Y<=result, zero/parity recomputed from result, out_valid<=1. acc/acc_pend untouched.
- ACC_XOR beat, last=0: acc<=acc^A^B, acc_pend<=1, no result produced; out_valid<=0 if the existing result is transferred this cycle, else out_valid/Y hold.
- ACC_XOR beat, last=1: Y<=acc^A^B, flags from that value, out_valid<=1, acc<=0, acc_pend<=0. Single-beat ACC (last=1, acc_pend=0) yields A^B.
- Non-ACC beats may interleave with an open accumulation; acc persists across them.
- No accepted beat producing a result: out_valid<=0 on output transfer, else hold.
- Backpressure: while out_valid && !out_ready, Y/zero/parity/out_valid hold stable and in_ready=0 (no beat lost or overwritten).
- Full throughput: with out_ready=1 continuously, one beat accepted per cycle; simultaneous output transfer and input transfer in the same cycle is legal (output register reloaded).
- Widths: all logic is bitwise, no carry; WIDTH=1 legal (parity==Y).
- Inputs are sampled only on transfer; changes on A/B/op while in_valid=0 or in_ready=0 have no effect.

Test Plan:
- Reset: hold rst=1 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, Y=0x00, zero=1, parity=0, acc_pend=0; no beat accepted.
- All ops, WIDTH=8, A=0xA5, B=0x3C, out_ready=1: next-cycle Y = 0x24, 0xBD, 0x99, 0xDB, 0x42, 0x66, 0x5A(op 110); flags e.g. 0x99 -> zero=0, parity=0; A=0xF0,B=0x0F op 000 -> Y=0x00, zero=1.
- Accumulate: op=111 beats (0x01,0x02,last0),(0x04,0x08,last0),(0x10,0x20,last1) -> no out_valid for first two, acc_pend=1 after first; after third Y=0x3F, parity=0, acc_pend=0; next single beat (0x11,0x01,last1) -> Y=0x10.
- Backpressure: issue XOR 0xFF^0x0F then hold out_ready=0 3 cycles with in_valid=1 -> Y=0xF0 stable, in_ready=0; release -> 0xF0 transferred, next beat accepted same cycle.
- Interleave + reset mid-accumulation: ACC (0x0F,0x00,last0), AND (0xFF,0x33) -> Y=0x33, acc_pend=1; ACC (0x00,0xF0,last1) -> Y=0xFF; repeat first beat, then rst=1 -> acc_pend=0; ACC (0x01,0x00,last1) -> Y=0x01.
- Throughput/param: WIDTH=1 and WIDTH=32 random 1000 beats with random valid/ready -> results match golden model in order, no drops/duplicates.
